// File: rtl/eth_cfg_arb.sv
// Round-robin arbiter sharing the eth_cfg register channel between NUM_REQ requesters.
// One transaction in flight at a time, with completion routing and a watchdog timeout.
module eth_cfg_arb #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned REG_ADDR_WIDTH = 32,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYC    = 1024
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [NUM_REQ-1:0]                req_wr_en,
  input  logic [NUM_REQ-1:0]                req_rd_en,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [1:0]                        req_resp,
  output logic [REG_DATA_WIDTH-1:0]         req_rd_data,
  input  logic                              cfg_busy,
  input  logic [1:0]                        cfg_resp,
  output logic                              cfg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0]         cfg_wr_addr,
  output logic [REG_DATA_WIDTH-1:0]         cfg_wr_data,
  output logic                              cfg_rd_en,
  output logic [REG_ADDR_WIDTH-1:0]         cfg_rd_addr,
  input  logic                              cfg_rd_vld,
  input  logic [REG_DATA_WIDTH-1:0]         cfg_rd_data,
  output logic                              arb_busy,
  output logic [2:0]                        arb_gnt_idx,
  output logic [15:0]                       timeout_cnt
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [2:0]                last_gnt_q, last_gnt_d;
  logic [2:0]                gnt_q, gnt_d;
  logic                      op_rd_q, op_rd_d;
  logic [31:0]               to_cnt_q, to_cnt_d;
  logic                      rd_got_q, rd_got_d;
  logic [REG_DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d, done_q, done_d;
  logic [1:0]                resp_q, resp_d;
  logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [REG_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                      busy_q, busy_d;
  logic [15:0]               to_tot_q, to_tot_d;

  // Requests padded to 8 bits so a 3-bit index always fits exactly.
  logic [7:0]         req_any8, req_wr8;
  logic [2:0]         arb_idx, win;
  logic               win_vld;
  logic [NUM_REQ-1:0] win_oh, gnt_oh;

  always_comb begin
    req_any8 = '0;
    req_wr8  = '0;
    req_any8[NUM_REQ-1:0] = req_wr_en | req_rd_en;
    req_wr8[NUM_REQ-1:0]  = req_wr_en;
    arb_idx = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_idx = 3'((32'(last_gnt_q) + 32'd1 + k) % NUM_REQ);
      if (!win_vld && req_any8[arb_idx]) begin
        win_vld = 1'b1;
        win     = arb_idx;
      end
    end
  end

  assign win_oh = NUM_REQ'(1) << win;
  assign gnt_oh = NUM_REQ'(1) << gnt_q;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    op_rd_d    = op_rd_q;
    to_cnt_d   = to_cnt_q;
    rd_got_d   = rd_got_q;
    rd_buf_d   = rd_buf_q;
    ack_d      = '0;
    done_d     = '0;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    to_tot_d   = to_tot_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StIssue;
          ack_d   = win_oh;
          gnt_d   = win;
          // A write wins over a simultaneous read from the same requester.
          op_rd_d = !req_wr8[win];
          if (req_wr8[win]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = req_addr[32'(win)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            wr_data_d = req_wr_data[32'(win)*REG_DATA_WIDTH +: REG_DATA_WIDTH];
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = req_addr[32'(win)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
          end
        end
      end
      StIssue: begin
        state_d    = StWait;
        last_gnt_d = gnt_q;
        to_cnt_d   = '0;
        rd_got_d   = 1'b0;
      end
      StWait: begin
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 32'd1;
        if (cfg_rd_vld) begin
          rd_got_d = 1'b1;
          rd_buf_d = cfg_rd_data;
        end
        // to_cnt_q == 0 marks the first WAIT cycle, before eth_cfg has raised busy.
        if (to_cnt_q != '0) begin
          if (!cfg_busy) begin
            state_d = StDone;
            done_d  = gnt_oh;
            resp_d  = cfg_resp;
            if (op_rd_q) begin
              if (cfg_rd_vld) begin
                rdata_d = cfg_rd_data;
              end else if (rd_got_q) begin
                rdata_d = rd_buf_q;
              end else begin
                rdata_d = '0;
                resp_d  = 2'b10;
              end
            end
          end else if ((TIMEOUT_CYC != 0) && (to_cnt_q + 32'd1 >= TIMEOUT_CYC)) begin
            state_d = StDrain;
            done_d  = gnt_oh;
            resp_d  = 2'b11;
            if (to_tot_q != 16'hFFFF) to_tot_d = to_tot_q + 16'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      StDrain: if (!cfg_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q    <= StIdle;
      last_gnt_q <= 3'(NUM_REQ - 1);
      gnt_q      <= '0;
      op_rd_q    <= 1'b0;
      to_cnt_q   <= '0;
      rd_got_q   <= 1'b0;
      rd_buf_q   <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      resp_q     <= '0;
      rdata_q    <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      to_tot_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      op_rd_q    <= op_rd_d;
      to_cnt_q   <= to_cnt_d;
      rd_got_q   <= rd_got_d;
      rd_buf_q   <= rd_buf_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      to_tot_q   <= to_tot_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_done    = done_q;
  assign req_resp    = resp_q;
  assign req_rd_data = rdata_q;
  assign cfg_wr_en   = wr_en_q;
  assign cfg_wr_addr = wr_addr_q;
  assign cfg_wr_data = wr_data_q;
  assign cfg_rd_en   = rd_en_q;
  assign cfg_rd_addr = rd_addr_q;
  assign arb_busy    = busy_q;
  assign arb_gnt_idx = gnt_q;
  assign timeout_cnt = to_tot_q;

endmodule
